// File: rtl/nfca_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nfca_rx_pkg : defaults, phase encoding and threshold helper for the NFC-A  |
// | median demodulator.                               Rev 1.0                  |
// +----------------------------------------------------------------------------+
package nfca_rx_pkg;

  localparam int DW     = 12;
  localparam int N      = 21;
  localparam int RANK   = 12;
  localparam int WARMUP = 32;
  localparam int TW     = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SORT   = 2'd2,
    RESULT = 2'd3
  } phase_e;

  // Threshold = lpf -/+ (lpf >> sh); sh==0 drops the term. Sub clamps at 0, add saturates at maxv.
  function automatic logic [TW-1:0] thr_calc(input logic [TW-1:0] lpf,
                                             input logic [3:0]    sh,
                                             input logic          add,
                                             input logic [TW-1:0] maxv);
    logic [TW-1:0] t;
    logic [TW-1:0] r;
    t = (sh == 4'd0) ? '0 : (lpf >> sh);
    if (add) begin
      r = lpf + t;
      if (r > maxv) r = maxv;
    end else begin
      r = (t > lpf) ? '0 : (lpf - t);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nfca_sort_net.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nfca_sort_net : odd-even transposition sort registers, one pass per step.  |
// |                                                   Rev 1.0                  |
// +----------------------------------------------------------------------------+
module nfca_sort_net #(
  parameter int DW = nfca_rx_pkg::DW,
  parameter int N  = nfca_rx_pkg::N
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 step,
  input  logic                 odd,
  input  logic [N-1:0][DW-1:0] load_vec,
  output logic [N-1:0][DW-1:0] sorted
);
  import nfca_rx_pkg::*;

  logic [N-1:0][DW-1:0] sorted_q, sorted_d;

  // Odd passes pair (0,1),(2,3)..; even passes pair (1,2),(3,4)..; pairs never overlap.
  always_comb begin
    sorted_d = sorted_q;
    if (load) begin
      sorted_d = load_vec;
    end else if (step) begin
      for (int i = 0; i < N - 1; i++) begin
        if ((((i % 2) == 0) == odd) && (sorted_q[i] > sorted_q[i+1])) begin
          sorted_d[i]   = sorted_q[i+1];
          sorted_d[i+1] = sorted_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sorted_q <= '0;
    end else begin
      sorted_q <= sorted_d;
    end
  end

  assign sorted = sorted_q;

endmodule
`default_nettype wire

// File: rtl/nfca_rx_median_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nfca_rx_median_demod : rank-filtered baseline with hysteretic ASK decision.|
// |                                                   Rev 1.0                  |
// +----------------------------------------------------------------------------+
module nfca_rx_median_demod #(
  parameter int DW      = nfca_rx_pkg::DW,
  parameter int N       = nfca_rx_pkg::N,
  parameter int RANK    = nfca_rx_pkg::RANK,
  parameter int RAW_TAP = (N - 1) / 2,
  parameter int WARMUP  = nfca_rx_pkg::WARMUP
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          adc_data_en,
  input  logic [DW-1:0] adc_data,
  input  logic          cfg_invert,
  input  logic [3:0]    cfg_on_shift,
  input  logic [3:0]    cfg_off_shift,
  output logic          rx_ask_en,
  output logic          rx_ask,
  output logic [DW-1:0] rx_lpf_data,
  output logic [DW-1:0] rx_raw_data,
  output logic          overrun
);
  import nfca_rx_pkg::*;

  localparam int            PW       = $clog2(N + 1);
  localparam int            IW       = $clog2(N);
  localparam logic [TW-1:0] MAXV     = TW'((1 << DW) - 1);
  localparam logic [7:0]    WARM_LIM = 8'(WARMUP);

  phase_e               phase_q, phase_d;
  logic [PW-1:0]        pass_q, pass_d;
  logic [7:0]           warm_q, warm_d;
  logic [N-1:0][DW-1:0] array_q;
  logic [N-1:0][DW-1:0] w_sorted;
  logic                 ask_q, ask_d, ask_en_q, ask_en_d, ovr_q, ovr_d;
  logic [DW-1:0]        lpf_q, lpf_d, raw_q, raw_d;
  logic                 w_load, w_step;
  logic [DW-1:0]        w_lpf, w_raw, w_thr_on, w_thr_off;
  logic                 w_set, w_clr, w_ask_next;

  function automatic logic [DW-1:0] rank_pick(input logic [N-1:0][DW-1:0] v,
                                              input logic [IW-1:0]        idx);
    return v[idx];
  endfunction

  nfca_sort_net #(.DW(DW), .N(N)) u_sort (
    .clk      (clk),
    .rstn     (rstn),
    .load     (w_load),
    .step     (w_step),
    .odd      (pass_q[0]),
    .load_vec (array_q),
    .sorted   (w_sorted)
  );

  assign w_lpf = rank_pick(w_sorted, IW'(RANK));
  assign w_raw = array_q[RAW_TAP];

  // Set has priority over clear; neither holds the previous level.
  always_comb begin
    w_thr_on  = DW'(thr_calc(TW'(w_lpf), cfg_on_shift,  cfg_invert, MAXV));
    w_thr_off = DW'(thr_calc(TW'(w_lpf), cfg_off_shift, cfg_invert, MAXV));
    if (cfg_invert) begin
      w_set = (w_raw > w_thr_on);
      w_clr = (w_raw <= w_thr_off);
    end else begin
      w_set = (w_raw < w_thr_on);
      w_clr = (w_raw >= w_thr_off);
    end
    w_ask_next = w_set | (ask_q & ~w_clr);
  end

  always_comb begin
    phase_d  = phase_q;
    pass_d   = pass_q;
    warm_d   = warm_q;
    ask_d    = ask_q;
    lpf_d    = lpf_q;
    raw_d    = raw_q;
    ask_en_d = 1'b0;
    ovr_d    = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    if (adc_data_en) begin
      ovr_d   = (phase_q != IDLE);
      phase_d = LOAD;
      pass_d  = PW'(1);
    end else begin
      case (phase_q)
        LOAD: begin
          w_load  = 1'b1;
          phase_d = SORT;
          pass_d  = PW'(1);
        end
        SORT: begin
          w_step = 1'b1;
          if (pass_q == PW'(N)) phase_d = RESULT;
          else                  pass_d  = pass_q + PW'(1);
        end
        RESULT: begin
          phase_d = IDLE;
          if (warm_q < WARM_LIM) begin
            warm_d = warm_q + 8'd1;
          end else begin
            ask_en_d = 1'b1;
            ask_d    = w_ask_next;
            lpf_d    = w_lpf;
            raw_d    = w_raw;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q  <= IDLE;
      pass_q   <= '0;
      warm_q   <= '0;
      array_q  <= '0;
      ask_q    <= 1'b0;
      ask_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      lpf_q    <= '0;
      raw_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      pass_q   <= pass_d;
      warm_q   <= warm_d;
      ask_q    <= ask_d;
      ask_en_q <= ask_en_d;
      ovr_q    <= ovr_d;
      lpf_q    <= lpf_d;
      raw_q    <= raw_d;
      if (adc_data_en) array_q <= {array_q[N-2:0], adc_data};
    end
  end

  assign rx_ask_en   = ask_en_q;
  assign rx_ask      = ask_q;
  assign rx_lpf_data = lpf_q;
  assign rx_raw_data = raw_q;
  assign overrun     = ovr_q;

endmodule
`default_nettype wire
